// File: rtl/i2c_rd_arbiter_pkg.sv
// Shared I2C definitions: arbiter FSM states and the address constants that
// the I2C read master also uses to build its address byte.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam logic I2C_RD_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic logic [7:0] i2c_rd_addr_byte(input logic [I2C_ADDR_W-1:0] addr);
    return {addr, I2C_RD_BIT};
  endfunction

endpackage

// File: rtl/i2c_rd_arbiter_if.sv
// Handshake bus between the read arbiter (master modport) and the I2C read
// engine (slave modport).
interface i2c_rd_arbiter_if
  import i2c_pkg::*;
#(
  parameter int ADDR_W = I2C_ADDR_W
);

  logic              m_start;
  logic [ADDR_W-1:0] m_addr;
  logic              m_busy;
  logic              m_done;
  logic [7:0]        m_rdata;
  logic              m_nack;

  modport master (
    output m_start, m_addr,
    input  m_busy, m_done, m_rdata, m_nack
  );

  modport slave (
    input  m_start, m_addr,
    output m_busy, m_done, m_rdata, m_nack
  );

endinterface

// File: rtl/i2c_rd_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo NREQ. Reusable for any shared-bus arbiter.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic             found_s;
  logic [IDX_W-1:0] j_s;

  // Walk the requests starting at ptr; the first one found wins.
  always_comb begin
    found_s  = 1'b0;
    j_s      = {IDX_W{1'b0}};
    idx_o    = {IDX_W{1'b0}};
    onehot_o = {NREQ{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      j_s = IDX_W'((int'(ptr_i) + k) % NREQ);
      if (!found_s && req_i[j_s]) begin
        found_s       = 1'b1;
        idx_o         = j_s;
        onehot_o[j_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/i2c_rd_arbiter.sv
// Round-robin arbiter sharing one I2C read master among NREQ requesters,
// with a per-transaction cycle timeout and a one-cycle done pulse per result.
module i2c_rd_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = I2C_ADDR_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [7:0]             rd_data,
  output logic                   rd_err,
  output logic                   rd_timeout,
  i2c_rd_arbiter_if.master       mbus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;

  logic [NREQ-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_valid_s;
  logic [ADDR_W-1:0] addr_arr_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr_s[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .valid_o  (pick_valid_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= {NREQ{1'b0}};
      win_q   <= {IDX_W{1'b0}};
      ptr_q   <= {IDX_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      data_q  <= 8'h00;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; a master result beats a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s && !mbus.m_busy) begin
          gnt_d   = pick_onehot_s;
          win_d   = pick_idx_s;
          addr_d  = addr_arr_s[pick_idx_s];
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        if (mbus.m_done) begin
          data_d  = mbus.m_rdata;
          err_d   = mbus.m_nack;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          data_d  = 8'h00;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        ptr_d   = (win_q == LAST_IDX) ? {IDX_W{1'b0}} : win_q + IDX_W'(1);
        gnt_d   = {NREQ{1'b0}};
        state_d = IDLE;
      end
      default: begin
        gnt_d   = {NREQ{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  assign gnt          = gnt_q;
  assign done         = (state_q == RESP) ? gnt_q : {NREQ{1'b0}};
  assign rd_data      = data_q;
  assign rd_err       = err_q;
  assign rd_timeout   = tmo_q;
  assign mbus.m_start = (state_q == ISSUE);
  assign mbus.m_addr  = addr_q;

endmodule

// File: tb/tb_i2c_rd_arbiter.sv
// Randomized self-checking bench for i2c_rd_arbiter against a transaction-level
// reference model (round-robin pick, latency and timeout arithmetic).
module tb_i2c_rd_arbiter;
  import i2c_pkg::*;

  localparam int NREQ    = 4;
  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 15;
  localparam int AW_ALL  = NREQ * ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [AW_ALL-1:0] req_addr = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rd_data;
  logic              rd_err, rd_timeout;

  i2c_rd_arbiter_if #(.ADDR_W(ADDR_W)) mb ();

  i2c_rd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .done       (done),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .rd_timeout (rd_timeout),
    .mbus       (mb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  int         ptr_m = 0;
  logic [7:0] last_data = 8'h00;
  int         last_start = -100;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference rule: first requester at or after ptr, modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] rq, input int p);
    logic [NREQ-1:0] t;
    for (int k = 0; k < NREQ; k++) begin
      t = rq >> ((p + k) % NREQ);
      if (t[0]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [AW_ALL-1:0] rand_addrs();
    logic [AW_ALL-1:0] a;
    a = '0;
    for (int i = 0; i < NREQ; i++) a = a | (AW_ALL'($urandom_range(0, 127)) << (i * ADDR_W));
    return a;
  endfunction

  function automatic int gnt_index(input logic [NREQ-1:0] g);
    logic [NREQ-1:0] t;
    int r;
    r = -1;
    for (int k = 0; k < NREQ; k++) begin
      t = g >> k;
      if (t[0]) r = k;
    end
    return r;
  endfunction

  // One full transaction: master answers in WAIT cycle n (never if n > TIMEOUT).
  task automatic run_txn(input logic [NREQ-1:0] rq, input logic [AW_ALL-1:0] addrs,
                         input int busy_cyc, input int n, input logic [7:0] rdata,
                         input logic nack, input bit spur, input bit chg, output int obs_win);
    int win, lat, c, exp_lat;
    bit seen;
    logic [NREQ-1:0]   oh;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_data;
    logic              exp_err, exp_tmo;
    win      = model_pick(rq, ptr_m);
    oh       = NREQ'(1) << win;
    exp_addr = ADDR_W'(addrs >> (win * ADDR_W));
    if (n <= TIMEOUT) begin
      exp_data = rdata; exp_err = nack; exp_tmo = 1'b0; exp_lat = n + 1;
    end else begin
      exp_data = 8'h00; exp_err = 1'b1; exp_tmo = 1'b1; exp_lat = TIMEOUT + 1;
    end
    req = rq; req_addr = addrs; mb.m_busy = (busy_cyc > 0); mb.m_done = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (lat >= busy_cyc) mb.m_busy = 1'b0;
      if (mb.m_start) seen = 1;
      else check_eq("no_done_before_start", 32'(done), 32'd0);
    end
    check_eq("start_latency", 32'(lat), 32'(busy_cyc + 1));
    check_eq("gnt_at_start", 32'(gnt), 32'(oh));
    check_eq("m_addr", 32'(mb.m_addr), 32'(exp_addr));
    check_eq("rd_data_held", 32'(rd_data), 32'(last_data));
    check_eq("start_spacing_ge3", 32'(cyc - last_start >= 3), 32'd1);
    last_start = cyc;
    obs_win = gnt_index(gnt);
    if (chg) begin
      req = NREQ'($urandom); req_addr = rand_addrs();
    end
    mb.m_done = spur; mb.m_busy = 1'b1;
    mb.m_rdata = 8'($urandom); mb.m_nack = 1'($urandom);
    @(posedge clk); #1;
    check_eq("start_one_cycle", 32'(mb.m_start), 32'd0);
    c = 0; seen = 0;
    while (!seen && c < TIMEOUT + 20) begin
      mb.m_done  = (c == n);
      mb.m_rdata = (c == n) ? rdata : 8'($urandom);
      mb.m_nack  = (c == n) ? nack : 1'($urandom);
      @(posedge clk); #1; c++;
      if (|done) seen = 1;
      else check_eq("gnt_held", 32'(gnt), 32'(oh));
    end
    check_eq("done_latency", 32'(c), 32'(exp_lat));
    check_eq("done_vec", 32'(done), 32'(oh));
    check_eq("gnt_in_resp", 32'(gnt), 32'(oh));
    check_eq("rd_data", 32'(rd_data), 32'(exp_data));
    check_eq("rd_err", 32'(rd_err), 32'(exp_err));
    check_eq("rd_timeout", 32'(rd_timeout), 32'(exp_tmo));
    check_eq("m_addr_stable", 32'(mb.m_addr), 32'(exp_addr));
    mb.m_busy = 1'b0; mb.m_done = spur;
    @(posedge clk); #1;
    mb.m_done = 1'b0;
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("gnt_cleared", 32'(gnt), 32'd0);
    ptr_m = (win + 1) % NREQ;
    last_data = exp_data;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check_eq({tag, "_rd_err"}, 32'(rd_err), 32'd0);
    check_eq({tag, "_rd_timeout"}, 32'(rd_timeout), 32'd0);
    check_eq({tag, "_m_start"}, 32'(mb.m_start), 32'd0);
    check_eq({tag, "_m_addr"}, 32'(mb.m_addr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rr_order [6];
    logic [AW_ALL-1:0] a;
    logic [NREQ-1:0] rq;
    bit seen;
    rr_order = '{0, 1, 2, 3, 0, 1};
    mb.m_busy = 1'b0; mb.m_done = 1'b0; mb.m_rdata = 8'h00; mb.m_nack = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // single request, address 0x55, data 0x0F
    a = rand_addrs();
    a[ADDR_W-1:0] = 7'h55;
    run_txn(4'b0001, a, 0, 12, 8'h0F, 1'b0, 1'b0, 1'b0, w);
    check_eq("single_winner", 32'(w), 32'd0);

    // NACK from the slave
    run_txn(4'b0100, rand_addrs(), 0, 5, 8'hAA, 1'b1, 1'b0, 1'b0, w);
    check_eq("nack_winner", 32'(w), 32'd2);

    // master never answers
    run_txn(4'b1000, rand_addrs(), 0, TIMEOUT + 5, 8'h77, 1'b0, 1'b1, 1'b0, w);

    // all requesting: strict rotation from requester 0
    for (int k = 0; k < 6; k++) begin
      run_txn(4'b1111, rand_addrs(), 0, $urandom_range(0, 6), 8'($urandom), 1'b0, 1'b0, 1'b0, w);
      check_eq("rr_order", 32'(w), 32'(rr_order[k]));
    end

    // answer lands on the timeout cycle: the master wins
    run_txn(4'b0001, rand_addrs(), 0, TIMEOUT, 8'h3C, 1'b0, 1'b0, 1'b0, w);

    // busy hold-off
    run_txn(4'b0010, rand_addrs(), 4, 3, 8'h5A, 1'b0, 1'b0, 1'b0, w);

    for (int k = 0; k < 40; k++) begin
      rq = NREQ'($urandom_range(1, 15));
      run_txn(rq, rand_addrs(), $urandom_range(0, 3), $urandom_range(0, TIMEOUT + 3),
              8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), w);
    end

    // reset in WAIT with the pointer away from 0
    run_txn(4'b0001, rand_addrs(), 0, 2, 8'h11, 1'b0, 1'b0, 1'b0, w);
    req = 4'b0010; req_addr = rand_addrs();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (mb.m_start) seen = 1;
    end
    check_eq("pre_reset_start_seen", 32'(seen), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; mb.m_busy = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    rst = 1'b0;
    ptr_m = 0; last_data = 8'h00; last_start = -100;
    run_txn(4'b1111, rand_addrs(), 3, 4, 8'hC3, 1'b0, 1'b0, 1'b0, w);
    check_eq("post_reset_winner", 32'(w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_rd_arbiter.md
Name: i2c_rd_arbiter

Overview:
- Shares one I2C read master (start/busy/done handshake, 7-bit address, 8-bit read data) between NREQ requesters, e.g. several sensor-voltage readers.
- Arbitrates round-robin and issues one read transaction per grant.
- Guards each transaction with a cycle timeout.
- Returns data and error status to the winning requester with a one-cycle done pulse.

Parameters:
- NREQ, 4: number of requesters (2..8).
- ADDR_W, 7: I2C slave address width.
- TIMEOUT, 1023: max clk cycles spent in WAIT before the transaction is aborted as an error.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  level request per requester; held high until its done pulse.
- req_addr  input  NREQ*ADDR_W  slave address per requester; slice i belongs to req[i].
- gnt  output  NREQ  one-hot grant; high from ISSUE through RESP.
- done  output  NREQ  one-cycle pulse to the granted requester when the result is valid.
- rd_data  output  8  read byte; valid while done is nonzero, held until the next RESP.
- rd_err  output  1  slave NACK or timeout; valid with done.
- rd_timeout  output  1  set with done when the error cause was a timeout.
- m_start  output  1  one-cycle transaction start to the I2C master.
- m_addr  output  ADDR_W  address to the master; stable from ISSUE until the next grant.
- m_busy  input  1  master is mid-transaction.
- m_done  input  1  one-cycle pulse from the master: transaction finished.
- m_rdata  input  8  master read byte; valid with m_done.
- m_nack  input  1  slave NACKed; valid with m_done.

Behaviour:
- Reset: state IDLE; gnt, done, rd_data, rd_err, rd_timeout, m_start, m_addr all 0; rr pointer 0, so requester 0 has top priority; timeout counter 0.
- Reset mid-transaction aborts silently: no done pulse. The master is not told; the next grant waits for m_busy low.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high and m_busy is low, pick the winner. Search starts at index ptr and goes upward modulo NREQ; the first req high wins. Latch the winner's gnt bit and its req_addr slice into m_addr, then go to ISSUE. If m_busy is high, stay in IDLE.
- ISSUE: m_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT, on m_done: rd_data<=m_rdata, rd_err<=m_nack, rd_timeout<=0, go to RESP.
- WAIT, otherwise: increment the counter. When counter==TIMEOUT, set rd_data<=0, rd_err<=1, rd_timeout<=1, and go to RESP.
- WAIT, m_done in the same cycle the counter hits TIMEOUT: m_done wins; there is no timeout.
- RESP: done[winner]=1 for this cycle only; ptr<=winner+1 (wrapping NREQ-1 to 0); clear gnt; go to IDLE.
- Latency: req sampled high in IDLE at edge E0 gives m_start high in the E0–E1 cycle. m_done sampled at edge Ek gives done high in the Ek–Ek+1 cycle.
- Minimum spacing between consecutive m_start pulses is 3 cycles plus master time.
- req dropped mid-transaction: the transaction still completes and done still pulses. The requester ignores it.
- req_addr changes after grant are ignored; the latched address is used.
- A winner whose req is still high after done is treated as a new request. It has lowest priority next round because of the ptr update.
- m_done seen in IDLE, ISSUE or RESP (spurious) is ignored.
- All outputs are registered or decoded from state registers only; no combinational path from req to m_start.
- Timeout counter width is clog2(TIMEOUT+1) and it saturates; it never wraps.

Decomposition:
- Shared package i2c_pkg: FSM state enum (IDLE, ISSUE, WAIT, RESP), the I2C_ADDR_W=7 constant, and the read-bit constant. The existing I2C master's address encoding uses the same constants.
- One natural sub-module: rr_picker. It is combinational, takes req[NREQ] and ptr, and returns a one-hot winner plus winner index and a valid flag. It is reusable for other shared-bus arbiters.

Test Plan:
- Single request:
  - Stimulus: reset; req=0001, addr0=0x55; master replies m_done after 20 cycles with m_rdata=0x0F, m_nack=0.
  - Required: m_start 1 cycle after req, m_addr=0x55, done=0001 1 cycle after m_done, rd_data=0x0F, rd_err=0.
- Round-robin fairness:
  - Stimulus: req=1111 held; master always completes.
  - Required: grant order 0,1,2,3,0,1; every gnt one-hot; never two m_start pulses closer than 3 cycles.
- NACK:
  - Stimulus: req=0100; master returns m_done with m_nack=1, m_rdata=0xAA.
  - Required: done=0100, rd_err=1, rd_timeout=0, rd_data=0xAA.
- Timeout:
  - Stimulus: TIMEOUT=15; master never pulses m_done.
  - Required: done pulses exactly 16 cycles after leaving ISSUE, with rd_err=1, rd_timeout=1, rd_data=0.
  - Variant: m_done arrives on the TIMEOUT cycle; required rd_timeout=0 and data taken from the master.
- Busy hold-off and reset:
  - Stimulus: m_busy=1 with req=0010.
  - Required: no m_start until m_busy drops; m_start the cycle after.
  - Stimulus: assert rst during WAIT.
  - Required: all outputs 0 next cycle, no done pulse, next grant goes to requester 0 if it is requesting.
